addsub_sequencer: RTL and testbench
===================================

// Module: addsub_sequencer
// PURPOSE
//  Command-side controller for the registered N-bit adder/subtractor datapath
//  (inputs A, B, Sel, AddSub; outputs Z, Overflow).
//  - Accepts operations on a valid/ready command port and drives the datapath.
//  - Tracks the datapath's 2-edge latency and returns Z/Overflow on a
//    valid/ready result port.
//  - Holds the datapath accumulator (Z) stable between operations, so Sel-based
//    accumulate works across commands.
// PARAMETERS
//  N    16   operand/result width; must match the datapath's n
// PORTS
//  Clock      in   1   rising-edge clock, shared with the datapath
//  Resetn     in   1   asynchronous, active-low reset; also wired to the datapath reset (inverted)
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   command accepted when cmd_valid & cmd_ready at a rising edge
//  cmd_a      in   N   operand A (ignored when cmd_acc=1)
//  cmd_b      in   N   operand B
//  cmd_sub    in   1   0 = add, 1 = subtract (drives AddSub)
//  cmd_acc    in   1   1 = first operand is the current Z (drives Sel)
//  res_valid  out  1   result present
//  res_ready  in   1   result consumed when res_valid & res_ready at a rising edge
//  res_z      out  N   captured datapath Z
//  res_ovf    out  1   captured datapath Overflow
//  dp_a       out  N   to datapath A
//  dp_b       out  N   to datapath B
//  dp_sel     out  1   to datapath Sel
//  dp_addsub  out  1   to datapath AddSub
//  dp_z       in   N   from datapath Z
//  dp_ovf     in   1   from datapath Overflow
//  ovf_clr    in   1   clears ovf_sticky (OVF_STICKY_EN only)
//  ovf_sticky out  1   sticky overflow flag (OVF_STICKY_EN only)
// BEHAVIOUR
//  - All outputs are registered. Reset values: state IDLE; cmd_ready=1 once in IDLE; res_valid=0;
//    res_z=0; res_ovf=0; dp_a=0; dp_b=0; dp_sel=0; dp_addsub=0; acc mirror=0.
//  - FSM: IDLE -> ISSUE -> WAIT1 -> WAIT2 -> RESP -> IDLE.
//    IDLE: cmd_ready=1. On accept, latch cmd_a, cmd_b, cmd_sub, cmd_acc into dp_* -> ISSUE.
//    ISSUE: dp_* hold the command for exactly one cycle; the datapath input registers load at
//      the end of this cycle -> WAIT1.
//    WAIT1: the datapath loads Z at the end of this cycle -> WAIT2.
//    WAIT2: sample dp_z/dp_ovf into res_z/res_ovf and the acc mirror; res_valid=1 -> RESP.
//    RESP: hold res_* until res_ready=1, then res_valid=0 -> IDLE.
//  - Latency: res_valid rises on the 3rd rising edge after the accept edge. Minimum command
//    spacing is 5 cycles. Only one operation is ever outstanding.
//  - Hold pattern in every state except ISSUE: dp_a=acc mirror, dp_b=0, dp_sel=0, dp_addsub=0.
//    The datapath therefore recomputes Z=acc+0, keeping Z equal to the last result
//    (overflow recomputes as 0 and is ignored).
//  - cmd_ready=0 in all states except IDLE; cmd_valid is ignored there. A command cannot be
//    accepted in the same cycle as the response handshake.
//  - Arithmetic is modulo 2^N in the datapath. This block passes values unmodified.
//    Subtract is A-B, or Z-B when cmd_acc=1.
//  - Resetn low at any time aborts any operation: immediate return to reset values, and any
//    in-flight result is discarded. The datapath Z also clears, so the mirror and Z agree.
// CONFIGURATION
//  OVF_STICKY_EN defined:
//    - ovf_sticky is set on the WAIT2->RESP edge when dp_ovf=1.
//    - It is cleared by ovf_clr=1; if set and clear coincide, set wins.
//    - Reset value is 0.
//  OVF_STICKY_EN undefined: ovf_clr and ovf_sticky ports are absent and no extra flops exist.
// TESTING
//  1. Reset, then cmd a=5 b=3 sub=0 acc=0 -> res_z=8, res_ovf=0; res_valid 3 edges after accept.
//  2. acc=1 b=10 add after test 1 -> res_z=18; then acc=1 b=20 sub -> res_z=16'hFFFE
//     (wrap-around).
//  3. Keep res_ready=0 for 10 cycles after result 7 -> res_z stays 7, cmd_ready=0,
//     dp_z stays 7; then acc=1 b=1 add -> 8.
//  4. cmd_valid held high continuously with varied operands -> exactly one accept per
//    5-cycle op; no command lost or duplicated.
//  5. Resetn pulsed low during WAIT1 -> res_valid never asserts; next cmd acc=1 b=4 add -> 4.
//  6. OVF_STICKY_EN: force dp_ovf=1 on one op -> ovf_sticky=1 through later clean ops;
//     ovf_clr pulse -> 0.

Source files
------------

// File: rtl/addsub_sequencer.sv
// addsub_sequencer: valid/ready command/result sequencer for a registered N-bit add/sub datapath (optional OVF_STICKY_EN adds a sticky overflow flag)
module addsub_sequencer #(
   parameter int N = 16
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [N-1:0] cmd_a,
   input  logic [N-1:0] cmd_b,
   input  logic         cmd_sub,
   input  logic         cmd_acc,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [N-1:0] res_z,
   output logic         res_ovf,
   output logic [N-1:0] dp_a,
   output logic [N-1:0] dp_b,
   output logic         dp_sel,
   output logic         dp_addsub,
   input  logic [N-1:0] dp_z,
   input  logic         dp_ovf
`ifdef OVF_STICKY_EN
   ,
   input  logic         ovf_clr,
   output logic         ovf_sticky
`endif
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT1, WAIT2, RESP} state_t;
   state_t       state;
   logic [N-1:0] acc;
   // Sequence one operation at a time; dp_* carry the command only in ISSUE and otherwise replay acc+0 so Z holds
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         res_valid <= 1'b0;
         res_z     <= '0;
         res_ovf   <= 1'b0;
         dp_a      <= '0;
         dp_b      <= '0;
         dp_sel    <= 1'b0;
         dp_addsub <= 1'b0;
         acc       <= '0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               dp_a      <= cmd_a;
               dp_b      <= cmd_b;
               dp_sel    <= cmd_acc;
               dp_addsub <= cmd_sub;
               cmd_ready <= 1'b0;
               state     <= ISSUE;
            end
            ISSUE: begin
               dp_a      <= acc;
               dp_b      <= '0;
               dp_sel    <= 1'b0;
               dp_addsub <= 1'b0;
               state     <= WAIT1;
            end
            WAIT1: state <= WAIT2;
            WAIT2: begin
               res_z     <= dp_z;
               res_ovf   <= dp_ovf;
               acc       <= dp_z;
               dp_a      <= dp_z;
               res_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: if (res_ready) begin
               res_valid <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef OVF_STICKY_EN
   // Sticky overflow: set when a result with overflow is captured, cleared by ovf_clr, set has priority
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) ovf_sticky <= 1'b0;
      else if (state == WAIT2 && dp_ovf) ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
   end
`endif
endmodule

// File: tb/tb_addsub_sequencer.sv
// tb_addsub_sequencer: randomized self-checking bench with a registered add/sub datapath and an integer reference model
module tb_addsub_sequencer;
   localparam int N = 16;
   logic         Clock = 1'b0;
   logic         Resetn = 1'b0;
   logic         cmd_valid = 1'b0, cmd_sub = 1'b0, cmd_acc = 1'b0, res_ready = 1'b0;
   logic [N-1:0] cmd_a = '0, cmd_b = '0;
   logic         cmd_ready, res_valid, res_ovf, dp_sel, dp_addsub, dp_ovf;
   logic [N-1:0] res_z, dp_a, dp_b, dp_z;
   logic         force_ovf = 1'b0;
`ifdef OVF_STICKY_EN
   logic         ovf_clr = 1'b0;
   logic         ovf_sticky;
`endif
   int errors = 0, checks = 0;
   int cyc = 0, n_acc = 0, n_res = 0;
   logic [N-1:0] acc_m = '0;

   addsub_sequencer #(.N(N)) dut (
      .Clock(Clock), .Resetn(Resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sub(cmd_sub), .cmd_acc(cmd_acc),
      .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_ovf(res_ovf),
      .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel), .dp_addsub(dp_addsub),
      .dp_z(dp_z), .dp_ovf(dp_ovf)
`ifdef OVF_STICKY_EN
      , .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
`endif
   );

   always #5 Clock = ~Clock;

   // Registered adder/subtractor datapath: inputs load on one edge, Z/Overflow on the next
   logic [N-1:0] ra, rb, zq, op1, bb, sum;
   logic         rs, rsub, oq, ov;
   assign op1 = rs ? zq : ra;
   assign bb  = rsub ? ~rb : rb;
   assign sum = op1 + bb + {{(N-1){1'b0}}, rsub};
   assign ov  = (op1[N-1] == bb[N-1]) && (sum[N-1] != op1[N-1]);
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         ra <= '0; rb <= '0; rs <= 1'b0; rsub <= 1'b0; zq <= '0; oq <= 1'b0;
      end else begin
         ra <= dp_a; rb <= dp_b; rs <= dp_sel; rsub <= dp_addsub; zq <= sum; oq <= ov;
      end
   end
   assign dp_z   = zq;
   assign dp_ovf = oq | force_ovf;

   // Handshake monitor
   always @(posedge Clock) begin
      cyc <= cyc + 1;
      if (cmd_valid && cmd_ready) n_acc <= n_acc + 1;
      if (res_valid && res_ready) n_res <= n_res + 1;
   end

   // Reference: signed integer arithmetic on the architectural accumulator
   function automatic void model(input logic [N-1:0] a, b, input logic sub, acc,
                                 output logic [N-1:0] z, output logic o);
      int x, y, r;
      x = acc ? int'($signed(acc_m)) : int'($signed(a));
      y = int'($signed(b));
      r = sub ? x - y : x + y;
      z = r[N-1:0];
      o = (r > 2**(N-1) - 1) || (r < -(2**(N-1)));
      acc_m = z;
   endfunction

   // Issue one command from a falling edge; lat = edges from accept to res_valid (-1 no accept, 0 no result)
   task automatic send(input logic [N-1:0] a, b, input logic sub, acc, output int lat);
      int w;
      cmd_a = a; cmd_b = b; cmd_sub = sub; cmd_acc = acc; cmd_valid = 1'b1;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 20) begin @(negedge Clock); w++; end
      if (w == 20) begin
         cmd_valid = 1'b0;
         lat = -1;
         return;
      end
      @(posedge Clock); #1 cmd_valid = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         @(posedge Clock); #1;
         if (res_valid === 1'b1) lat = i;
      end
      @(negedge Clock);
   endtask

   task automatic take();
      res_ready = 1'b1;
      @(posedge Clock); #1 res_ready = 1'b0;
      @(negedge Clock);
   endtask

   task automatic test_reset();
      Resetn = 1'b0;
      repeat (2) @(negedge Clock);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
      checks++; if (res_z !== '0) begin errors++; $display("FAIL reset_res_z got=%h exp=0", res_z); end
      checks++; if (res_ovf !== 1'b0) begin errors++; $display("FAIL reset_res_ovf got=%b exp=0", res_ovf); end
      checks++; if (dp_a !== '0 || dp_b !== '0) begin errors++; $display("FAIL reset_dp_ab got=%h/%h exp=0/0", dp_a, dp_b); end
      checks++; if (dp_sel !== 1'b0 || dp_addsub !== 1'b0) begin errors++; $display("FAIL reset_dp_ctl got=%b%b exp=00", dp_sel, dp_addsub); end
      Resetn = 1'b1;
      acc_m = '0;
      @(negedge Clock);
   endtask

   task automatic test_basic();
      int lat;
      logic [N-1:0] ez;
      logic eo;
      model(16'd5, 16'd3, 1'b0, 1'b0, ez, eo);
      send(16'd5, 16'd3, 1'b0, 1'b0, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", lat); end
      checks++; if (res_z !== ez || ez !== 16'd8) begin errors++; $display("FAIL basic_z got=%h exp=%h", res_z, ez); end
      checks++; if (res_ovf !== eo) begin errors++; $display("FAIL basic_ovf got=%b exp=%b", res_ovf, eo); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL basic_busy_ready got=%b exp=0", cmd_ready); end
      take();
      checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL basic_after_take got=%b%b exp=01", res_valid, cmd_ready); end
   endtask

   task automatic test_accumulate();
      int lat;
      logic [N-1:0] ez, a, b;
      logic eo, s, c;
      model(16'hBEEF, 16'd10, 1'b0, 1'b1, ez, eo);
      send(16'hBEEF, 16'd10, 1'b0, 1'b1, lat);
      checks++; if (res_z !== ez || ez !== 16'd18) begin errors++; $display("FAIL acc_add got=%h exp=%h", res_z, ez); end
      take();
      model(16'h1111, 16'd20, 1'b1, 1'b1, ez, eo);
      send(16'h1111, 16'd20, 1'b1, 1'b1, lat);
      checks++; if (res_z !== ez || ez !== 16'hFFFE) begin errors++; $display("FAIL acc_wrap got=%h exp=%h", res_z, ez); end
      checks++; if (res_ovf !== eo) begin errors++; $display("FAIL acc_wrap_ovf got=%b exp=%b", res_ovf, eo); end
      take();
      for (int k = 0; k < 12; k++) begin
         a = N'($urandom); b = N'($urandom); s = 1'($urandom); c = 1'($urandom);
         model(a, b, s, c, ez, eo);
         send(a, b, s, c, lat);
         checks++; if (lat !== 3) begin errors++; $display("FAIL rand_latency[%0d] got=%0d exp=3", k, lat); end
         checks++; if (res_z !== ez || res_ovf !== eo) begin errors++; $display("FAIL rand_result[%0d] a=%h b=%h sub=%b acc=%b got=%h/%b exp=%h/%b", k, a, b, s, c, res_z, res_ovf, ez, eo); end
         take();
      end
   endtask

   task automatic test_hold();
      int lat;
      logic [N-1:0] ez;
      logic eo;
      model(16'd3, 16'd4, 1'b0, 1'b0, ez, eo);
      send(16'd3, 16'd4, 1'b0, 1'b0, lat);
      cmd_a = 16'h7777; cmd_b = 16'h1; cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checks++; if (res_valid !== 1'b1 || res_z !== 16'd7) begin errors++; $display("FAIL hold_res[%0d] got=%b/%h exp=1/0007", i, res_valid, res_z); end
         checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL hold_cmd_ready[%0d] got=%b exp=0", i, cmd_ready); end
         if (i >= 2) begin
            checks++; if (dp_z !== 16'd7) begin errors++; $display("FAIL hold_dp_z[%0d] got=%h exp=0007", i, dp_z); end
         end
         @(negedge Clock);
      end
      cmd_valid = 1'b0;
      take();
      model(16'h0, 16'd1, 1'b0, 1'b1, ez, eo);
      send(16'h0, 16'd1, 1'b0, 1'b1, lat);
      checks++; if (res_z !== ez || ez !== 16'd8) begin errors++; $display("FAIL hold_next got=%h exp=%h", res_z, ez); end
      take();
   endtask

   task automatic test_back_to_back();
      int w, prev, a0, r0;
      logic [N-1:0] ez;
      logic eo;
      prev = -1; a0 = n_acc; r0 = n_res;
      res_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cmd_a = N'($urandom); cmd_b = N'($urandom); cmd_sub = 1'($urandom); cmd_acc = 1'($urandom);
         cmd_valid = 1'b1;
         w = 0;
         while (cmd_ready !== 1'b1 && w < 20) begin @(negedge Clock); w++; end
         checks++; if (w == 20) begin errors++; $display("FAIL b2b_accept_timeout[%0d] got=no_ready exp=ready", k); break; end
         if (prev >= 0) begin
            checks++; if (cyc - prev !== 5) begin errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp=5", k, cyc - prev); end
         end
         prev = cyc;
         model(cmd_a, cmd_b, cmd_sub, cmd_acc, ez, eo);
         @(posedge Clock);
         @(negedge Clock);
         w = 0;
         while (res_valid !== 1'b1 && w < 10) begin @(negedge Clock); w++; end
         checks++; if (res_z !== ez || res_ovf !== eo) begin errors++; $display("FAIL b2b_result[%0d] got=%h/%b exp=%h/%b", k, res_z, res_ovf, ez, eo); end
      end
      cmd_valid = 1'b0;
      repeat (2) @(negedge Clock);
      res_ready = 1'b0;
      checks++; if (n_acc - a0 !== 8) begin errors++; $display("FAIL b2b_accepts got=%0d exp=8", n_acc - a0); end
      checks++; if (n_res - r0 !== 8) begin errors++; $display("FAIL b2b_results got=%0d exp=8", n_res - r0); end
   endtask

   task automatic test_reset_abort();
      int w, seen, lat;
      logic [N-1:0] ez;
      logic eo;
      cmd_a = 16'd9; cmd_b = 16'd9; cmd_sub = 1'b0; cmd_acc = 1'b0; cmd_valid = 1'b1;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 20) begin @(negedge Clock); w++; end
      @(posedge Clock); #1 cmd_valid = 1'b0;
      @(posedge Clock);
      @(negedge Clock);
      Resetn = 1'b0;
      @(negedge Clock);
      checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_in_reset got=%b%b exp=01", res_valid, cmd_ready); end
      Resetn = 1'b1;
      acc_m = '0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clock);
         if (res_valid === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_result got=%0d exp=0", seen); end
      model(16'h55, 16'd4, 1'b0, 1'b1, ez, eo);
      send(16'h55, 16'd4, 1'b0, 1'b1, lat);
      checks++; if (res_z !== ez || ez !== 16'd4) begin errors++; $display("FAIL abort_next got=%h exp=%h", res_z, ez); end
      take();
   endtask

`ifdef OVF_STICKY_EN
   task automatic test_sticky();
      int lat;
      logic [N-1:0] ez;
      logic eo;
      checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_initial got=%b exp=0", ovf_sticky); end
      force_ovf = 1'b1;
      model(16'd1, 16'd1, 1'b0, 1'b0, ez, eo);
      send(16'd1, 16'd1, 1'b0, 1'b0, lat);
      force_ovf = 1'b0;
      checks++; if (res_ovf !== 1'b1 || ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set got=%b%b exp=11", res_ovf, ovf_sticky); end
      take();
      for (int k = 0; k < 2; k++) begin
         model(16'd0, 16'd1, 1'b0, 1'b1, ez, eo);
         send(16'd0, 16'd1, 1'b0, 1'b1, lat);
         checks++; if (res_ovf !== 1'b0 || ovf_sticky !== 1'b1 || res_z !== ez) begin errors++; $display("FAIL sticky_hold[%0d] got=%b%b/%h exp=01/%h", k, res_ovf, ovf_sticky, res_z, ez); end
         take();
      end
      ovf_clr = 1'b1;
      @(posedge Clock); #1 ovf_clr = 1'b0;
      @(negedge Clock);
      checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear got=%b exp=0", ovf_sticky); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_accumulate();
      test_hold();
      test_back_to_back();
      test_reset_abort();
`ifdef OVF_STICKY_EN
      test_sticky();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
